nlp_table: RTL and testbench
============================

# nlp_table

Next-line predictor (NLP) storage for the fetch unit. It answers two-slot lookups issued from IF_1 with registered `nlpInfo` records consumed in IF_2/IF_3. It also absorbs the `NLPUpdate` stream produced by IF_3, creating, training and retargeting entries. The block is the responder/storage end of the NLP update interface driven by the IF_3 stage.

## Interface

Parameters:
- `ENTRIES`, 16: number of fully-associative entries. Must be a power of two, at least 2.
- `PTR_W`, $clog2(ENTRIES): width of the replacement pointer.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-low (0 = reset asserted).
- `lookup_en`, in, 1: capture a new lookup this cycle. When 0, the response registers hold.
- `lookup_pc`, in, 32: fetch-group PC, 8-byte aligned. Slot0 = `lookup_pc`, slot1 = `lookup_pc + 4`.
- `pred0_valid` / `pred1_valid`, out, 1: slot hit (maps to `nlpInfo.valid`).
- `pred0_taken` / `pred1_taken`, out, 1: counter MSB of the hit entry (`nlpInfo.taken`).
- `pred0_target` / `pred1_target`, out, 32: stored target (`nlpInfo.target`).
- `pred0_bim` / `pred1_bim`, out, 2: stored 2-bit counter (`nlpInfo.bimState`).
- `upd_valid`, in, 1: update strobe from IF_3.
- `upd_pc`, in, 32: PC of the predicted control instruction.
- `upd_target`, in, 32: target decided by IF_3.
- `upd_bim`, in, 2: counter state supplied by IF_3. IF_3 sends the entry's state on a hit, or 2'b01 when there was no NLP hit.
- `upd_taken`, in, 1: IF_3 `shouldTake`.

## Operation

- Entry contents: `v`, `tag[31:2]`, `target[31:0]`, `bim[1:0]`.
- Lookup: each slot compares `{pc[31:2]}` against all valid tags in parallel. At most one entry matches, which the allocation rules guarantee.
  - On a hit: `predN_valid` = 1, `predN_taken` = bim[1], target and bim taken from the entry.
  - On a miss: all `predN_*` fields = 0.
- Update match: `upd_pc[31:2]` is compared against all valid tags. The new counter is `nb` = saturating(`upd_bim` + 1) if `upd_taken`, otherwise saturating(`upd_bim` − 1), clamped to the range 0..3.
- Update hit:
  - The entry's bim is set to `nb`.
  - If `upd_taken`, the target is set to `upd_target`; otherwise the target is unchanged.
  - The entry is never invalidated, even when `nb` = 0.
- Update miss with `upd_taken` = 1: allocate into entry `rr_ptr` with v = 1, tag, target = `upd_target`, bim = `nb`. Then `rr_ptr` ← `rr_ptr` + 1, wrapping from ENTRIES−1 to 0.
- Update miss with `upd_taken` = 0: no state change and no allocation.
- Replacement: round-robin. Allocation overwrites the pointed entry even if it is valid (eviction). `rr_ptr` advances only on allocation.
- No flush input. Pipeline flushes do not modify the table.

## Timing

- Lookup latency is 1 cycle. With `lookup_en` = 1 at edge N, the `pred*` outputs reflect table contents as they were before edge N and are stable from N until the next enabled edge.
- Update latency is 1 cycle: the table write occurs at the edge where `upd_valid` = 1.
- Lookup and update in the same cycle on the same PC: no bypass. The lookup returns the old entry, and the new state is visible to lookups captured at the next enabled edge or later.
- Update and lookup are fully independent and may occur every cycle. `upd_valid` has no handshake; the block always accepts it.
- Reset (asynchronous, `rst` = 0):
  - All `v` = 0 and `rr_ptr` = 0.
  - All `pred*` outputs = 0 immediately.
  - Tag, target and bim contents need not be cleared.
  - After `rst` returns to 1, the first enabled lookup misses.
- Reset asserted mid-operation: an in-flight update at that edge is discarded.
- Both slots may hit different entries in the same lookup.

## Test plan

- Reset: drive `rst` = 0 asynchronously mid-cycle -> all `pred*` = 0 at once. After release, lookup 0x1FC00000 -> `pred0_valid` = `pred1_valid` = 0.
- Allocate and hit:
  - Update pc = 0x80000004, target = 0x80000100, bim = 2'b01, taken = 1.
  - Then lookup 0x80000000 -> `pred1_valid` = 1, taken = 1, target = 0x80000100, bim = 2'b10, and `pred0_valid` = 0.
- Training:
  - Three not-taken updates on that PC, each feeding back the returned bim (10→01→00→00 saturate) -> lookup gives valid = 1, taken = 0, bim = 0, target unchanged.
  - Two taken updates with target 0x80000200 -> bim = 2'b10, target = 0x80000200.
- Not-taken miss: update pc = 0x80000010 with taken = 0 -> lookup 0x80000010 misses and `rr_ptr` is unchanged.
- Eviction wrap: ENTRIES+1 distinct taken updates -> the first PC misses, the rest hit, and `rr_ptr` = 1.
- Same-cycle hazard:
  - Update and lookup on 0x80000020 in the same cycle -> that lookup misses.
  - Next lookup -> hit.
  - With `lookup_en` = 0 afterwards, the outputs hold.

Source files
------------

// File: rtl/nlp_table.sv
// Next-line predictor storage: fully-associative table answering two-slot
// lookups with registered predictions and absorbing training/allocation updates.
module nlp_table #(
  parameter int ENTRIES = 16,
  parameter int PTR_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_en,
  input  logic [31:0] lookup_pc,
  output logic        pred0_valid,
  output logic        pred0_taken,
  output logic [31:0] pred0_target,
  output logic [1:0]  pred0_bim,
  output logic        pred1_valid,
  output logic        pred1_taken,
  output logic [31:0] pred1_target,
  output logic [1:0]  pred1_bim,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic [1:0]  upd_bim,
  input  logic        upd_taken
);

  function automatic logic [1:0] next_bim(input logic [1:0] b, input logic tk);
    logic [1:0] r;
    r = b;
    if (tk) begin
      if (b != 2'b11) r = b + 2'd1;
      else            r = b;
    end else begin
      if (b != 2'b00) r = b - 2'd1;
      else            r = b;
    end
    return r;
  endfunction

  logic [ENTRIES-1:0] valid_r;
  logic [29:0]        tag_r    [ENTRIES];
  logic [31:0]        target_r [ENTRIES];
  logic [1:0]         bim_r    [ENTRIES];
  logic [PTR_W-1:0]   rr_ptr_r;

  logic [29:0]        slot0_tag_s, slot1_tag_s;
  logic [ENTRIES-1:0] m0_s, m1_s, mu_s, we_s;
  logic               hit0_s, hit1_s, upd_hit_s, alloc_s;
  logic [31:0]        tgt0_s, tgt1_s;
  logic [1:0]         bim0_s, bim1_s, nb_s;
  logic               unused_s;

  assign slot0_tag_s = lookup_pc[31:2];
  assign slot1_tag_s = lookup_pc[31:2] + 30'd1;
  assign nb_s        = next_bim(upd_bim, upd_taken);
  assign unused_s    = &{1'b0, lookup_pc[1:0], upd_pc[1:0]};

  // Parallel tag match; allocation keeps matches one-hot, so OR-merging is exact.
  always_comb begin
    m0_s = '0;
    m1_s = '0;
    mu_s = '0;
    we_s = '0;
    tgt0_s = 32'd0;
    tgt1_s = 32'd0;
    bim0_s = 2'd0;
    bim1_s = 2'd0;
    for (int i = 0; i < ENTRIES; i++) begin
      m0_s[i] = valid_r[i] && (tag_r[i] == slot0_tag_s);
      m1_s[i] = valid_r[i] && (tag_r[i] == slot1_tag_s);
      mu_s[i] = valid_r[i] && (tag_r[i] == upd_pc[31:2]);
      tgt0_s  = tgt0_s | ({32{m0_s[i]}} & target_r[i]);
      tgt1_s  = tgt1_s | ({32{m1_s[i]}} & target_r[i]);
      bim0_s  = bim0_s | ({2{m0_s[i]}} & bim_r[i]);
      bim1_s  = bim1_s | ({2{m1_s[i]}} & bim_r[i]);
    end
    hit0_s    = |m0_s;
    hit1_s    = |m1_s;
    upd_hit_s = |mu_s;
    alloc_s   = upd_valid && !upd_hit_s && upd_taken;
    for (int i = 0; i < ENTRIES; i++) begin
      we_s[i] = (upd_valid && mu_s[i]) || (alloc_s && (rr_ptr_r == PTR_W'(i)));
    end
  end

  // Valid bits and replacement pointer; reset wins over any same-edge update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      valid_r <= valid_r | we_s;
      if (alloc_s) rr_ptr_r <= rr_ptr_r + PTR_W'(1);
      else         rr_ptr_r <= rr_ptr_r;
    end
  end

  // Entry payload; gated by valid_r so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (we_s[i]) begin
        tag_r[i]    <= upd_pc[31:2];
        target_r[i] <= upd_taken ? upd_target : target_r[i];
        bim_r[i]    <= nb_s;
      end
    end
  end

  // Registered prediction records, held while lookup_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred0_valid  <= 1'b0;
      pred0_taken  <= 1'b0;
      pred0_target <= 32'd0;
      pred0_bim    <= 2'd0;
      pred1_valid  <= 1'b0;
      pred1_taken  <= 1'b0;
      pred1_target <= 32'd0;
      pred1_bim    <= 2'd0;
    end else if (lookup_en) begin
      pred0_valid  <= hit0_s;
      pred0_taken  <= bim0_s[1];
      pred0_target <= tgt0_s;
      pred0_bim    <= bim0_s;
      pred1_valid  <= hit1_s;
      pred1_taken  <= bim1_s[1];
      pred1_target <= tgt1_s;
      pred1_bim    <= bim1_s;
    end
  end

endmodule

// File: tb/tb_nlp_table.sv
// Randomized + directed bench for nlp_table against a behavioural table model.
module tb_nlp_table;
  localparam int ENTRIES = 16;

  logic        clk, rst, lookup_en, upd_valid, upd_taken;
  logic [31:0] lookup_pc, upd_pc, upd_target;
  logic [1:0]  upd_bim;
  logic        pred0_valid, pred0_taken, pred1_valid, pred1_taken;
  logic [31:0] pred0_target, pred1_target;
  logic [1:0]  pred0_bim, pred1_bim;

  int checks = 0;
  int failures = 0;

  nlp_table #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred0_valid(pred0_valid), .pred0_taken(pred0_taken),
    .pred0_target(pred0_target), .pred0_bim(pred0_bim),
    .pred1_valid(pred1_valid), .pred1_taken(pred1_taken),
    .pred1_target(pred1_target), .pred1_bim(pred1_bim),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_bim(upd_bim), .upd_taken(upd_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: list of {pc, target, counter} records plus a round-robin slot number.
  logic        m_v   [ENTRIES];
  logic [31:0] m_pc  [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_cnt [ENTRIES];
  int          m_ptr;
  logic [35:0] exp0, exp1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_find(input logic [31:0] pc);
    for (int i = 0; i < ENTRIES; i++)
      if (m_v[i] && (m_pc[i] >> 2) == (pc >> 2)) return i;
    return -1;
  endfunction

  function automatic logic [35:0] m_look(input logic [31:0] pc);
    int k;
    logic [1:0] b;
    k = m_find(pc);
    if (k < 0) return 36'd0;
    b = 2'(m_cnt[k]);
    return {1'b1, b[1], m_tgt[k], b};
  endfunction

  task automatic m_update(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [1:0] bim, input logic tk);
    int k, n;
    n = tk ? int'(bim) + 1 : int'(bim) - 1;
    if (n > 3) n = 3;
    if (n < 0) n = 0;
    k = m_find(pc);
    if (k >= 0) begin
      m_cnt[k] = n;
      if (tk) m_tgt[k] = tgt;
    end else if (tk) begin
      m_v[m_ptr] = 1'b1; m_pc[m_ptr] = pc; m_tgt[m_ptr] = tgt; m_cnt[m_ptr] = n;
      m_ptr = (m_ptr + 1) % ENTRIES;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
    m_ptr = 0;
    exp0 = 36'd0;
    exp1 = 36'd0;
  endtask

  // One clock: drive after negedge, model the edge (lookup sees old state), check at +1.
  task automatic step(input string tag, input logic le, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic [1:0] ubim, input logic utk);
    @(negedge clk);
    lookup_en = le; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_bim = ubim; upd_taken = utk;
    @(posedge clk);
    if (le) begin
      exp0 = m_look(lpc);
      exp1 = m_look(lpc + 32'd4);
    end
    if (uv) m_update(upc, utgt, ubim, utk);
    #1;
    check({tag, "_s0"}, 64'({pred0_valid, pred0_taken, pred0_target, pred0_bim}), 64'(exp0));
    check({tag, "_s1"}, 64'({pred1_valid, pred1_taken, pred1_target, pred1_bim}), 64'(exp1));
  endtask

  task automatic upd(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic [1:0] b, input logic tk);
    step(tag, 1'b0, 32'd0, 1'b1, pc, tgt, b, tk);
  endtask

  task automatic look(input string tag, input logic [31:0] pc);
    step(tag, 1'b1, pc, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    m_reset();
    #1;
    check("rst_async_out", 64'({pred0_valid, pred0_taken, pred0_target, pred0_bim,
                                pred1_valid, pred1_taken, pred1_target, pred1_bim}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] pc, tg;
    logic [1:0]  b;
    int k;
    rst = 1'b1; lookup_en = 1'b0; lookup_pc = 32'd0; upd_valid = 1'b0;
    upd_pc = 32'd0; upd_target = 32'd0; upd_bim = 2'd0; upd_taken = 1'b0;
    m_reset();
    #3 rst = 1'b0;
    #10 rst = 1'b1;
    look("post_rst", 32'h1FC0_0000);
    check("post_rst_v0", 64'(pred0_valid), 64'd0);

    // Allocate, then hit on slot1; mid-cycle reset must clear a live hit at once.
    upd("alloc", 32'h8000_0004, 32'h8000_0100, 2'b01, 1'b1);
    look("hit1", 32'h8000_0000);
    check("hit1_exact", 64'({pred1_valid, pred1_taken, pred1_target, pred1_bim}),
          64'({1'b1, 1'b1, 32'h8000_0100, 2'b10}));
    do_reset();
    look("miss_after_rst", 32'h8000_0000);

    upd("alloc2", 32'h8000_0004, 32'h8000_0100, 2'b01, 1'b1);
    b = 2'b10;
    for (int i = 0; i < 3; i++) begin
      upd("nt_train", 32'h8000_0004, 32'h0, b, 1'b0);
      look("nt_look", 32'h8000_0000);
      b = pred1_bim;
    end
    check("nt_sat", 64'({pred1_valid, pred1_bim, pred1_target}), 64'({1'b1, 2'b00, 32'h8000_0100}));
    for (int i = 0; i < 2; i++) begin
      upd("tk_train", 32'h8000_0004, 32'h8000_0200, b, 1'b1);
      look("tk_look", 32'h8000_0000);
      b = pred1_bim;
    end
    check("tk_final", 64'({pred1_bim, pred1_target}), 64'({2'b10, 32'h8000_0200}));

    upd("nt_miss", 32'h8000_0010, 32'h1234_5678, 2'b01, 1'b0);
    look("nt_miss_look", 32'h8000_0010);
    check("nt_miss_ptr", 64'(dut.rr_ptr_r), 64'(m_ptr));

    // Eviction wrap from a clean table.
    do_reset();
    for (int i = 0; i <= ENTRIES; i++)
      upd("evict_upd", 32'h9000_0000 + 32'(8 * i), 32'hA000_0000 + 32'(i), 2'b01, 1'b1);
    check("evict_ptr", 64'(dut.rr_ptr_r), 64'd1);
    for (int i = 0; i <= ENTRIES; i++) look("evict_look", 32'h9000_0000 + 32'(8 * i));
    look("evict_first", 32'h9000_0000);
    check("evict_first_miss", 64'(pred0_valid), 64'd0);

    // Same-cycle update/lookup: no bypass, then visible, then hold.
    step("hazard", 1'b1, 32'h8000_0020, 1'b1, 32'h8000_0020, 32'h8000_0400, 2'b01, 1'b1);
    check("hazard_miss", 64'(pred0_valid), 64'd0);
    look("hazard_next", 32'h8000_0020);
    check("hazard_hit", 64'(pred0_valid), 64'd1);
    for (int i = 0; i < 3; i++)
      step("hold", 1'b0, 32'h9000_0008, 1'b1, 32'h8000_0020, 32'h0, 2'b11, 1'b0);

    // Random traffic over a small PC pool to force hits, training and evictions.
    for (int n = 0; n < 600; n++) begin
      pc = 32'h8000_1000 + 32'(4 * $urandom_range(0, 23));
      tg = $urandom;
      k = m_find(pc);
      if ($urandom_range(0, 1) == 0) b = (k >= 0) ? 2'(m_cnt[k]) : 2'b01;
      else b = 2'($urandom_range(0, 3));
      step("rand", 1'($urandom_range(0, 1)), 32'h8000_1000 + 32'(8 * $urandom_range(0, 11)),
           1'($urandom_range(0, 1)), pc, tg, b, 1'($urandom_range(0, 1)));
    end
    check("rand_ptr", 64'(dut.rr_ptr_r), 64'(m_ptr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
